// File: rtl/if_fetch_tx_pkg.sv
// Shared constants and state encoding for the fetch-side transmitter.
// Holds reset PC, prediction tag width, FSM states and packet alignment.
package if_fetch_tx_pkg;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int          PTAB_W   = 5;
  localparam logic [3:0]  PKT_OFS  = 4'b0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_POST
  } fetch_st_e;

endpackage

// File: rtl/if_next_pc.sv
// Next fetch PC selector: sequential line, predicted target, or delay slot.
// In: current line, latched prediction, pending delay slot; out: npc, set_dslot.
module if_next_pc
  import if_fetch_tx_pkg::*;
(
  input  logic [27:0] pc_line,
  input  logic        pred,
  input  logic [31:0] bpc,
  input  logic [31:0] tgt,
  input  logic        dslot,
  input  logic [31:0] dtgt,
  output logic [31:0] npc,
  output logic        set_dslot
);

  logic in_w3;
  logic sel_ds;
  logic sel_w3;
  logic sel_tgt;

  assign in_w3   = (bpc[3:2] == 2'b11);
  assign sel_ds  = dslot;
  assign sel_w3  = !dslot && pred && in_w3;
  assign sel_tgt = !dslot && pred && !in_w3;

  always_comb begin
    npc       = {pc_line + 28'd1, PKT_OFS};
    set_dslot = 1'b0;
    unique case (1'b1)
      sel_ds:  npc = dtgt;
      // Slot lives in the next line; fetch it alone, target later.
      sel_w3: begin
        npc       = bpc + 32'd4;
        set_dslot = 1'b1;
      end
      sel_tgt: npc = tgt;
      default: ;
    endcase
  end

endmodule

// File: rtl/if_fetch_tx.sv
// Fetch PC owner: issues 16-byte fetches, tags predictions, feeds the IB.
// Ports: clk/rst_, flush, mem_* request/response, bp_* hints, icache_ib_* out.
module if_fetch_tx #(
  parameter logic [31:0] RESET_PC = if_fetch_tx_pkg::RESET_PC,
  parameter int          PTAB_W   = if_fetch_tx_pkg::PTAB_W
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              flush,
  input  logic [31:0]       flush_pc,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [127:0]      mem_rdata,
  input  logic              bp_hit,
  input  logic [31:0]       bp_branch_pc,
  input  logic [31:0]       bp_target,
  input  logic [PTAB_W-2:0] bp_idx,
  output logic [127:0]      icache_ib_insn,
  output logic [31:0]       icache_ib_pc,
  output logic [PTAB_W-1:0] icache_ib_ptab_addr,
  output logic [31:0]       icache_ib_branch_pc,
  output logic              icache_ib_delot_en,
  output logic              icache_valid_ns,
  input  logic              ib_allin
);

  import if_fetch_tx_pkg::*;

  fetch_st_e         state;
  fetch_st_e         state_n;
  logic [31:0]       pc;
  logic              discard;
  logic              discard_n;
  logic              dslot_pend;
  logic [31:0]       dtgt;
  logic              pv_q;
  logic [31:0]       bpc_q;
  logic [31:0]       tgt_q;
  logic [PTAB_W-2:0] idx_q;
  logic [31:0]       npc;
  logic              set_ds;
  logic              pred_ok;
  logic              accept;
  logic              load;
  logic              hand;

  assign pred_ok = bp_hit
                && (bp_branch_pc[31:4] == pc[31:4])
                && (bp_branch_pc >= pc);

  assign mem_req  = (state == S_REQ) && !discard && !rst_;
  assign mem_addr = {pc[31:4], PKT_OFS};
  assign icache_valid_ns = (state == S_HOLD);

  assign accept = mem_req && mem_addr_ok;
  assign load   = (state == S_WAIT) && mem_data_ok && !flush;
  assign hand   = (state == S_HOLD) && ib_allin && !flush;

  if_next_pc u_next_pc (
    .pc_line   (pc[31:4]),
    .pred      (pv_q),
    .bpc       (bpc_q),
    .tgt       (tgt_q),
    .dslot     (dslot_pend),
    .dtgt      (dtgt),
    .npc       (npc),
    .set_dslot (set_ds)
  );

  always_comb begin
    state_n   = state;
    discard_n = discard;
    unique case (state)
      S_REQ:  if (accept) state_n = S_WAIT;
      S_WAIT: if (mem_data_ok) state_n = S_HOLD;
      S_HOLD: if (ib_allin) state_n = S_POST;
      S_POST: state_n = S_REQ;
      default: state_n = S_REQ;
    endcase
    if (discard && mem_data_ok) discard_n = 1'b0;
    // A request still in flight must have its data swallowed.
    if (flush) begin
      state_n = S_REQ;
      if (((state == S_WAIT) && !mem_data_ok) || accept)
        discard_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state               <= S_REQ;
      pc                  <= RESET_PC;
      discard             <= 1'b0;
      dslot_pend          <= 1'b0;
      dtgt                <= '0;
      pv_q                <= 1'b0;
      bpc_q               <= '0;
      tgt_q               <= '0;
      idx_q               <= '0;
      icache_ib_insn      <= '0;
      icache_ib_pc        <= '0;
      icache_ib_ptab_addr <= '0;
      icache_ib_branch_pc <= '0;
      icache_ib_delot_en  <= 1'b0;
    end else begin
      state   <= state_n;
      discard <= discard_n;
      if (accept) begin
        pv_q  <= pred_ok;
        bpc_q <= bp_branch_pc;
        tgt_q <= bp_target;
        idx_q <= bp_idx;
      end
      if (load) begin
        icache_ib_insn     <= mem_rdata;
        icache_ib_pc       <= pc;
        icache_ib_delot_en <= dslot_pend;
        // Delay-slot packets never carry a prediction tag.
        icache_ib_ptab_addr <= (pv_q && !dslot_pend) ?
                               {1'b1, idx_q} : '0;
        icache_ib_branch_pc <= (pv_q && !dslot_pend) ?
                               bpc_q : '0;
      end
      if (flush) begin
        pc         <= flush_pc;
        dslot_pend <= 1'b0;
      end else if (hand) begin
        pc         <= npc;
        dslot_pend <= set_ds;
        if (set_ds) dtgt <= tgt_q;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_tx.sv
// Bench for if_fetch_tx: memory/predictor stubs, packet model, directed tests.
// Checks every presented packet and hold cycle against the model.
module tb_if_fetch_tx;

  logic         clk = 1'b0;
  logic         rst_;
  logic         flush;
  logic [31:0]  flush_pc;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_addr_ok;
  logic         mem_data_ok;
  logic [127:0] mem_rdata;
  logic         bp_hit;
  logic [31:0]  bp_branch_pc;
  logic [31:0]  bp_target;
  logic [3:0]   bp_idx;
  logic [127:0] insn;
  logic [31:0]  ib_pc;
  logic [4:0]   ptab;
  logic [31:0]  br_pc;
  logic         delot;
  logic         valid;
  logic         ib_allin;

  always #5 clk = ~clk;

  if_fetch_tx dut (
    .clk                 (clk),
    .rst_                (rst_),
    .flush               (flush),
    .flush_pc            (flush_pc),
    .mem_req             (mem_req),
    .mem_addr            (mem_addr),
    .mem_addr_ok         (mem_addr_ok),
    .mem_data_ok         (mem_data_ok),
    .mem_rdata           (mem_rdata),
    .bp_hit              (bp_hit),
    .bp_branch_pc        (bp_branch_pc),
    .bp_target           (bp_target),
    .bp_idx              (bp_idx),
    .icache_ib_insn      (insn),
    .icache_ib_pc        (ib_pc),
    .icache_ib_ptab_addr (ptab),
    .icache_ib_branch_pc (br_pc),
    .icache_ib_delot_en  (delot),
    .icache_valid_ns     (valid),
    .ib_allin            (ib_allin)
  );

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] memf(input logic [31:0] a);
    return {~(a + 32'd12), ~(a + 32'd8), ~(a + 32'd4), ~a};
  endfunction

  // predictor stub: one configurable line
  logic        cfg_hit = 1'b0;
  logic [31:0] cfg_line = '0;
  logic [31:0] cfg_bpc = '0;
  logic [31:0] cfg_tgt = '0;
  logic [3:0]  cfg_idx = '0;

  assign bp_hit       = cfg_hit && (mem_addr == cfg_line);
  assign bp_branch_pc = cfg_bpc;
  assign bp_target    = cfg_tgt;
  assign bp_idx       = cfg_idx;

  // memory stub
  int          lat = 0;
  logic        aok_en = 1'b1;
  logic        pend = 1'b0;
  int          wcnt = 0;
  logic [31:0] pend_addr = '0;
  logic        aok_d = 1'b0;
  logic        req_d = 1'b0;
  logic [31:0] addr_d = '0;
  logic [31:0] acc_log[$];

  initial begin
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    forever begin
      @(negedge clk);
      mem_data_ok = 1'b0;
      if (rst_) begin
        pend  = 1'b0;
        aok_d = 1'b0;
        req_d = 1'b0;
      end else begin
        if (aok_d && req_d) begin
          chk("one_outstanding", {127'd0, pend}, 128'd0);
          pend      = 1'b1;
          pend_addr = addr_d;
          wcnt      = lat;
          acc_log.push_back(addr_d);
        end
        if (pend) begin
          if (wcnt == 0) begin
            mem_data_ok = 1'b1;
            mem_rdata   = memf(pend_addr);
            pend        = 1'b0;
          end else begin
            wcnt--;
          end
        end
      end
      mem_addr_ok = aok_en;
      aok_d       = aok_en;
      req_d       = mem_req;
      addr_d      = mem_addr;
    end
  end

  // packet model
  logic [31:0] m_pc = RST_PC;
  logic        m_ds = 1'b0;
  logic [31:0] m_dtgt = '0;

  logic [31:0] log_pc[$];
  logic [4:0]  log_pt[$];
  logic [31:0] log_bpc[$];
  logic        log_ds[$];

  initial begin : cmp
    logic         v_prev;
    logic         a_prev;
    logic         f_prev;
    logic         pv;
    logic [31:0]  e_pc;
    logic [127:0] e_insn;
    logic [4:0]   e_pt;
    logic [31:0]  e_bpc;
    logic         e_ds;
    v_prev = 1'b0;
    a_prev = 1'b0;
    f_prev = 1'b0;
    e_pc = '0; e_insn = '0; e_pt = '0; e_bpc = '0; e_ds = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_) begin
        v_prev = 1'b0;
        continue;
      end
      if (mem_req)
        chk("mem_addr", mem_addr, {m_pc[31:4], 4'b0});
      if (v_prev && !f_prev) begin
        chk("hold_valid", valid, !a_prev);
        chk("hold_pc", ib_pc, e_pc);
        chk("hold_insn", insn, e_insn);
        chk("hold_ptab", ptab, e_pt);
        chk("hold_bpc", br_pc, e_bpc);
        chk("hold_delot", delot, e_ds);
      end
      if (valid && !v_prev) begin
        pv = !m_ds && cfg_hit
          && ({m_pc[31:4], 4'b0} == cfg_line)
          && (cfg_bpc[31:4] == m_pc[31:4])
          && (cfg_bpc >= m_pc);
        e_pc   = m_pc;
        e_insn = memf({m_pc[31:4], 4'b0});
        e_pt   = pv ? {1'b1, cfg_idx} : 5'd0;
        e_bpc  = pv ? cfg_bpc : 32'd0;
        e_ds   = m_ds;
        chk("pkt_pc", ib_pc, e_pc);
        chk("pkt_insn", insn, e_insn);
        chk("pkt_ptab", ptab, e_pt);
        chk("pkt_bpc", br_pc, e_bpc);
        chk("pkt_delot", delot, e_ds);
        log_pc.push_back(ib_pc);
        log_pt.push_back(ptab);
        log_bpc.push_back(br_pc);
        log_ds.push_back(delot);
        if (m_ds) begin
          m_pc = m_dtgt;
          m_ds = 1'b0;
        end else if (pv && cfg_bpc[3:2] == 2'b11) begin
          m_pc   = cfg_bpc + 32'd4;
          m_ds   = 1'b1;
          m_dtgt = cfg_tgt;
        end else if (pv) begin
          m_pc = cfg_tgt;
        end else begin
          m_pc = {m_pc[31:4] + 28'd1, 4'b0};
        end
      end
      v_prev = valid;
      a_prev = ib_allin;
      f_prev = flush;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pkts(input int n, input string nm);
    int b;
    b = 0;
    while (log_pc.size() < n && b < 200) begin
      tick();
      b++;
    end
    chk(nm, {127'd0, log_pc.size() >= n}, 128'd1);
  endtask

  task automatic wait_pend(input string nm);
    int b;
    b = 0;
    while (!pend && b < 100) begin
      tick();
      b++;
    end
    chk(nm, {127'd0, pend}, 128'd1);
  endtask

  task automatic do_flush(input logic [31:0] t);
    flush    = 1'b1;
    flush_pc = t;
    tick();
    flush = 1'b0;
    m_pc  = t;
    m_ds  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int na;
    rst_     = 1'b1;
    flush    = 1'b0;
    flush_pc = '0;
    ib_allin = 1'b1;
    repeat (3) tick();
    chk("rst_req", mem_req, 0);
    chk("rst_valid", valid, 0);
    chk("rst_insn", insn, 0);
    chk("rst_pc", ib_pc, 0);
    chk("rst_ptab", ptab, 0);
    chk("rst_bpc", br_pc, 0);
    chk("rst_delot", delot, 0);

    // 1: sequential fetch, first request stalled by memory
    aok_en = 1'b0;
    rst_   = 1'b0;
    repeat (3) begin
      tick();
      chk("t1_req_held", mem_req, 1);
    end
    aok_en = 1'b1;
    wait_pkts(3, "t1_pkts");
    chk("t1_pc0", log_pc[0], 32'hBFC0_0000);
    chk("t1_pc1", log_pc[1], 32'hBFC0_0010);
    chk("t1_pc2", log_pc[2], 32'hBFC0_0020);
    chk("t1_pt0", log_pt[0], 0);
    chk("t1_ds0", log_ds[0], 0);

    // 2: branch in word 1
    cfg_hit  = 1'b1;
    cfg_line = 32'h1000;
    cfg_bpc  = 32'h1004;
    cfg_tgt  = 32'h2008;
    cfg_idx  = 4'd3;
    do_flush(32'h1000);
    n0 = log_pc.size();
    wait_pkts(n0 + 2, "t2_pkts");
    chk("t2_pc0", log_pc[n0], 32'h1000);
    chk("t2_pt0", log_pt[n0], 5'b10011);
    chk("t2_bpc0", log_bpc[n0], 32'h1004);
    chk("t2_pc1", log_pc[n0+1], 32'h2008);
    chk("t2_pt1", log_pt[n0+1], 0);

    // 3: branch in word 3, delay slot in next line
    cfg_bpc = 32'h100C;
    cfg_tgt = 32'h3000;
    cfg_idx = 4'h9;
    do_flush(32'h1000);
    n0 = log_pc.size();
    wait_pkts(n0 + 3, "t3_pkts");
    chk("t3_pc0", log_pc[n0], 32'h1000);
    chk("t3_pt0", log_pt[n0], 5'h19);
    chk("t3_bpc0", log_bpc[n0], 32'h100C);
    chk("t3_pc1", log_pc[n0+1], 32'h1010);
    chk("t3_ds1", log_ds[n0+1], 1);
    chk("t3_pt1", log_pt[n0+1], 0);
    chk("t3_bpc1", log_bpc[n0+1], 0);
    chk("t3_pc2", log_pc[n0+2], 32'h3000);
    chk("t3_ds2", log_ds[n0+2], 0);

    // 3b: hit whose branch lies before the fetch pc is ignored
    cfg_bpc = 32'h1004;
    cfg_tgt = 32'h2008;
    do_flush(32'h1008);
    n0 = log_pc.size();
    wait_pkts(n0 + 2, "t3b_pkts");
    chk("t3b_pc0", log_pc[n0], 32'h1008);
    chk("t3b_pt0", log_pt[n0], 0);
    chk("t3b_bpc0", log_bpc[n0], 0);
    chk("t3b_pc1", log_pc[n0+1], 32'h1010);

    // 4: IB back-pressure
    ib_allin = 1'b0;
    n0 = log_pc.size();
    wait_pkts(n0 + 1, "t4_pkt");
    chk("t4_pc", log_pc[n0], 32'h1020);
    repeat (5) begin
      tick();
      chk("t4_valid", valid, 1);
      chk("t4_insn", insn, memf(32'h1020));
      chk("t4_ibpc", ib_pc, 32'h1020);
    end
    ib_allin = 1'b1;
    tick();
    chk("t4_post_valid", valid, 0);
    chk("t4_post_insn", insn, memf(32'h1020));
    tick();
    chk("t4_req_valid", valid, 0);
    chk("t4_req_insn", insn, memf(32'h1020));

    // 5: flush while waiting for data
    lat = 3;
    wait_pend("t5_pend");
    n0 = log_pc.size();
    do_flush(32'h4000);
    lat = 0;
    wait_pkts(n0 + 1, "t5_pkt");
    chk("t5_pc", log_pc[n0], 32'h4000);

    // 6: async reset mid-wait
    lat = 3;
    wait_pend("t6_pend");
    rst_ = 1'b1;
    #1;
    chk("t6_valid", valid, 0);
    chk("t6_req", mem_req, 0);
    chk("t6_insn", insn, 0);
    chk("t6_pc", ib_pc, 0);
    chk("t6_ptab", ptab, 0);
    m_pc = RST_PC;
    m_ds = 1'b0;
    repeat (2) tick();
    lat  = 0;
    na   = acc_log.size();
    n0   = log_pc.size();
    rst_ = 1'b0;
    wait_pkts(n0 + 1, "t6_pkt");
    chk("t6_pkt_pc", log_pc[n0], RST_PC);
    chk("t6_first_req", acc_log[na], RST_PC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
